// File: rtl/sr_flag_bank.sv
// sr_flag_bank
// Bank of CHANNELS independent clocked set/reset flags. This is the clocked
// successor to a single SR latch, used as a sticky status/interrupt register.
// Each channel also provides a one-cycle rising-edge pulse and a saturating
// count of its 0->1 transitions.
//
// Ports
//   i_clk      rising-edge clock
//   i_rst      synchronous active-high reset
//   i_s        per-channel set request (polarity chosen by ACTIVE_LOW)
//   i_r        per-channel reset request (polarity chosen by ACTIVE_LOW)
//   i_cnt_clr  active-high per-channel counter clear
//   o_q        registered flag state
//   o_rise     one-cycle pulse, high in the first cycle that q[i] reads 1
//   o_any_q    OR-reduction of the flag register
//   o_cnt      per-channel set-event counters, channel i at [i*CNT_W +: CNT_W]
//
// Parameters
//   CHANNELS       number of flags (1..32)
//   ACTIVE_LOW     1: s/r asserted when 0, 0: asserted when 1
//   CONFLICT_MODE  s and r both asserted: 0 hold, 1 set, 2 reset, 3 toggle,
//                  any other value behaves as hold
//   CNT_W          width of each saturating counter
//   RESET_VAL      flag value loaded on reset
module sr_flag_bank #(
  parameter int                    CHANNELS      = 8,
  parameter int                    ACTIVE_LOW    = 1,
  parameter int                    CONFLICT_MODE = 1,
  parameter int                    CNT_W         = 4,
  parameter logic [CHANNELS-1:0]   RESET_VAL     = '0
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [CHANNELS-1:0]       i_s,
  input  logic [CHANNELS-1:0]       i_r,
  input  logic [CHANNELS-1:0]       i_cnt_clr,
  output logic [CHANNELS-1:0]       o_q,
  output logic [CHANNELS-1:0]       o_rise,
  output logic                      o_any_q,
  output logic [CHANNELS*CNT_W-1:0] o_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CHANNELS-1:0]       r_q;
  logic [CHANNELS-1:0]       r_rise;
  logic [CHANNELS*CNT_W-1:0] r_cnt;

  logic [CHANNELS-1:0]       w_set;
  logic [CHANNELS-1:0]       w_clr;
  logic [CHANNELS-1:0]       w_q_next;
  logic [CHANNELS-1:0]       w_rise_next;
  logic [CHANNELS*CNT_W-1:0] w_cnt_next;
  logic [CNT_W-1:0]          w_cnt_cur;

  // Normalise request polarity so the rest of the logic sees active-high
  // set/clear regardless of the source convention.
  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (ACTIVE_LOW != 0) begin
      w_set = ~i_s;
      w_clr = ~i_r;
    end else begin
      w_set = i_s;
      w_clr = i_r;
    end
  end

  // Next flag state per channel. A simultaneous set and clear is resolved
  // by CONFLICT_MODE; out-of-range modes fall back to holding the flag.
  always_comb begin
    w_q_next = r_q;
    for (int i = 0; i < CHANNELS; i++) begin
      case ({w_set[i], w_clr[i]})
        2'b10:   w_q_next[i] = 1'b1;
        2'b01:   w_q_next[i] = 1'b0;
        2'b11: begin
          case (CONFLICT_MODE)
            1:       w_q_next[i] = 1'b1;
            2:       w_q_next[i] = 1'b0;
            3:       w_q_next[i] = ~r_q[i];
            default: w_q_next[i] = r_q[i];
          endcase
        end
        default: w_q_next[i] = r_q[i];
      endcase
    end
    w_rise_next = ~r_q & w_q_next;
  end

  // Counter update: a clear wins over a same-edge increment, so that event
  // is deliberately dropped. Increments stop at all-ones instead of wrapping.
  always_comb begin
    w_cnt_next = r_cnt;
    w_cnt_cur  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_cnt_cur = r_cnt[i*CNT_W +: CNT_W];
      if (i_cnt_clr[i]) begin
        w_cnt_next[i*CNT_W +: CNT_W] = '0;
      end else if (w_rise_next[i] && (w_cnt_cur != CNT_MAX)) begin
        w_cnt_next[i*CNT_W +: CNT_W] = w_cnt_cur + CNT_ONE;
      end
    end
  end

  // State registers. Reset overrides every request, including counter clears.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q    <= RESET_VAL;
      r_rise <= '0;
      r_cnt  <= '0;
    end else begin
      r_q    <= w_q_next;
      r_rise <= w_rise_next;
      r_cnt  <= w_cnt_next;
    end
  end

  assign o_q     = r_q;
  assign o_rise  = r_rise;
  assign o_cnt   = r_cnt;
  // Derived only from the register so it never glitches with s/r activity.
  assign o_any_q = |r_q;

endmodule

// File: tb/tb_sr_flag_bank.sv
// tb_sr_flag_bank
// Directed bench for sr_flag_bank. Four instances with RESET_VAL=0 cover
// conflict modes 0..3 and share one stimulus; a fifth instance (set-dominant,
// RESET_VAL=8'hA5) covers non-zero reset values.
module tb_sr_flag_bank;

  logic        clk;
  logic        rst;
  logic [7:0]  sIn;
  logic [7:0]  rIn;
  logic [7:0]  cntClr;

  logic [7:0]  qOut    [5];
  logic [7:0]  riseOut [5];
  logic        anyQ    [5];
  logic [31:0] cntOut  [5];

  int vecCount = 0;
  int errCount = 0;

  // One instance per conflict mode, all reset to zero.
  for (genvar g = 0; g < 4; g++) begin : gMode
    sr_flag_bank #(
      .CHANNELS(8), .ACTIVE_LOW(1), .CONFLICT_MODE(g), .CNT_W(4), .RESET_VAL(8'h00)
    ) uDut (
      .i_clk(clk), .i_rst(rst), .i_s(sIn), .i_r(rIn), .i_cnt_clr(cntClr),
      .o_q(qOut[g]), .o_rise(riseOut[g]), .o_any_q(anyQ[g]), .o_cnt(cntOut[g])
    );
  end

  // Non-zero reset value instance.
  sr_flag_bank #(
    .CHANNELS(8), .ACTIVE_LOW(1), .CONFLICT_MODE(1), .CNT_W(4), .RESET_VAL(8'hA5)
  ) uDutRv (
    .i_clk(clk), .i_rst(rst), .i_s(sIn), .i_r(rIn), .i_cnt_clr(cntClr),
    .o_q(qOut[4]), .o_rise(riseOut[4]), .o_any_q(anyQ[4]), .o_cnt(cntOut[4])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs between edges, then let one rising edge happen and settle.
  task automatic applyStimulus(input logic rstV, input logic [7:0] sV,
                               input logic [7:0] rV, input logic [7:0] clrV);
    rst    = rstV;
    sIn    = sV;
    rIn    = rV;
    cntClr = clrV;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    vecCount++;
    assert (obs === exp) else begin
      errCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bit b of q across modes 3..0, packed as {m3,m2,m1,m0}.
  function automatic logic [3:0] modeBits(input int b);
    return {qOut[3][b], qOut[2][b], qOut[1][b], qOut[0][b]};
  endfunction

  initial begin
    rst = 1'b1; sIn = 8'hFF; rIn = 8'hFF; cntClr = 8'h00;

    // Reset held two edges.
    applyStimulus(1'b1, 8'hFF, 8'hFF, 8'h00);
    applyStimulus(1'b1, 8'hFF, 8'hFF, 8'h00);
    checkOutput("rst_q_rv",    32'(qOut[4]),    32'h0000_00A5);
    checkOutput("rst_rise_rv", 32'(riseOut[4]), 32'h0);
    checkOutput("rst_cnt_rv",  cntOut[4],       32'h0);
    checkOutput("rst_anyq_rv", 32'(anyQ[4]),    32'h1);
    checkOutput("rst_q_m1",    32'(qOut[1]),    32'h0);
    checkOutput("rst_anyq_m1", 32'(anyQ[1]),    32'h0);

    // Set ch0, hold three cycles, then reset it.
    applyStimulus(1'b0, 8'hFE, 8'hFF, 8'h00);
    checkOutput("set0_q",    32'(qOut[1]),    32'h01);
    checkOutput("set0_rise", 32'(riseOut[1]), 32'h01);
    checkOutput("set0_cnt",  cntOut[1],       32'h1);
    checkOutput("set0_anyq", 32'(anyQ[1]),    32'h1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 8'hFF, 8'hFF, 8'h00);
      checkOutput("hold0_q",    32'(qOut[1]),    32'h01);
      checkOutput("hold0_rise", 32'(riseOut[1]), 32'h00);
    end
    applyStimulus(1'b0, 8'hFF, 8'hFE, 8'h00);
    checkOutput("clr0_q",    32'(qOut[1]),    32'h00);
    checkOutput("clr0_rise", 32'(riseOut[1]), 32'h00);
    checkOutput("clr0_cnt",  cntOut[1],       32'h1);

    // Conflict on ch1 starting from 0: {m3,m2,m1,m0}.
    applyStimulus(1'b0, 8'hFD, 8'hFD, 8'h00);
    checkOutput("conf_e1_q",    32'(modeBits(1)), 32'b1010);
    checkOutput("conf_e1_rise", 32'(riseOut[3]),  32'h02);
    applyStimulus(1'b0, 8'hFD, 8'hFD, 8'h00);
    checkOutput("conf_e2_q",    32'(modeBits(1)), 32'b0010);
    checkOutput("conf_e2_rise", 32'(riseOut[3]),  32'h00);
    applyStimulus(1'b0, 8'hFD, 8'hFD, 8'h00);
    checkOutput("conf_e3_q",    32'(modeBits(1)), 32'b1010);
    checkOutput("conf_e3_rise", 32'(riseOut[3]),  32'h02);
    applyStimulus(1'b0, 8'hFD, 8'hFD, 8'h00);
    checkOutput("conf_e4_q",    32'(modeBits(1)), 32'b0010);
    checkOutput("conf_m3_cnt1", 32'(cntOut[3][7:4]), 32'h2);
    checkOutput("conf_m1_cnt1", 32'(cntOut[1][7:4]), 32'h1);
    checkOutput("conf_m2_cnt1", 32'(cntOut[2][7:4]), 32'h0);

    // Conflict on ch4 starting from 1.
    applyStimulus(1'b0, 8'hEF, 8'hFF, 8'h00);
    checkOutput("conf4_set", 32'(modeBits(4)), 32'b1111);
    applyStimulus(1'b0, 8'hEF, 8'hEF, 8'h00);
    checkOutput("conf4_e1", 32'(modeBits(4)), 32'b0011);
    applyStimulus(1'b0, 8'hEF, 8'hEF, 8'h00);
    checkOutput("conf4_e2", 32'(modeBits(4)), 32'b1011);

    // Saturation on ch3: 20 set/reset pulses.
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1'b0, 8'hF7, 8'hFF, 8'h00);
      checkOutput("sat_cnt3", 32'(cntOut[1][15:12]), (k + 1 > 15) ? 32'd15 : 32'(k + 1));
      applyStimulus(1'b0, 8'hFF, 8'hF7, 8'h00);
    end
    checkOutput("sat_q3", 32'(qOut[1][3]), 32'h0);

    // Clear beats increment on ch2.
    applyStimulus(1'b0, 8'hFB, 8'hFF, 8'h04);
    checkOutput("clrinc_q2",    32'(qOut[1][2]),        32'h1);
    checkOutput("clrinc_rise2", 32'(riseOut[1][2]),     32'h1);
    checkOutput("clrinc_cnt2",  32'(cntOut[1][11:8]),   32'h0);
    applyStimulus(1'b0, 8'hFF, 8'hFF, 8'h00);
    checkOutput("clrinc_after", 32'(cntOut[1][11:8]),   32'h0);
    checkOutput("clrinc_fall",  32'(riseOut[1][2]),     32'h0);

    // All channels at once, then reset mid-operation.
    applyStimulus(1'b1, 8'hFF, 8'hFF, 8'h00);
    checkOutput("mid_rst_anyq", 32'(anyQ[1]), 32'h0);
    applyStimulus(1'b0, 8'h00, 8'hFF, 8'h00);
    checkOutput("all_rise",    32'(riseOut[1]), 32'hFF);
    checkOutput("all_q",       32'(qOut[1]),    32'hFF);
    checkOutput("all_anyq",    32'(anyQ[1]),    32'h1);
    checkOutput("all_rise_rv", 32'(riseOut[4]), 32'h5A);
    applyStimulus(1'b1, 8'h00, 8'hFF, 8'h00);
    checkOutput("hold_rst_q",    32'(qOut[1]),    32'h00);
    checkOutput("hold_rst_q_rv", 32'(qOut[4]),    32'hA5);
    checkOutput("hold_rst_rise", 32'(riseOut[4]), 32'h00);
    checkOutput("hold_rst_cnt",  cntOut[1],       32'h0);
    applyStimulus(1'b0, 8'h00, 8'hFF, 8'h00);
    checkOutput("rel_q_rv",    32'(qOut[4]),    32'hFF);
    checkOutput("rel_rise_rv", 32'(riseOut[4]), 32'h5A);
    checkOutput("rel_rise",    32'(riseOut[1]), 32'hFF);
    checkOutput("rel_cnt",     cntOut[1],       32'h1111_1111);
    checkOutput("rel_cnt_rv",  cntOut[4],       32'h0101_1010);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
